// File: rtl/writeback_regfile.sv
// writeback_regfile: SEQ Y86-64 write-back stage and architectural register file.
// Chooses destination registers from icode/rA/rB/Cnd, commits valE/valM on the
// rising clock edge, and tracks processor status (AOK/HLT/INS) and the number
// of retired instructions.
// Optional feature macro: RSP_RESET_EN -- when defined, %rsp (reg4) resets to
// RSP_INIT instead of zero.
module writeback_regfile #(
  parameter int          CNT_W    = 32,
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             Cnd,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  output logic [63:0]      reg0,
  output logic [63:0]      reg1,
  output logic [63:0]      reg2,
  output logic [63:0]      reg3,
  output logic [63:0]      reg4,
  output logic [63:0]      reg5,
  output logic [63:0]      reg6,
  output logic [63:0]      reg7,
  output logic [63:0]      reg8,
  output logic [63:0]      reg9,
  output logic [63:0]      reg10,
  output logic [63:0]      reg11,
  output logic [63:0]      reg12,
  output logic [63:0]      reg13,
  output logic [63:0]      reg14,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    INS = 3'd4
  } stat_t;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'd4;

`ifdef RSP_RESET_EN
  localparam logic [63:0] RSP_RESET_VAL = RSP_INIT;
`else
  localparam logic [63:0] RSP_RESET_VAL = 64'd0;
  logic unused_rsp_init;
  assign unused_rsp_init = ^RSP_INIT;
`endif

  stat_t       state;
  logic [63:0] rf [15];
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;

  // Destination register selection from the current instruction fields
  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (icode)
      4'h2:                   dst_e = Cnd ? rB : REG_NONE;
      4'h3, 4'h6:             dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = REG_RSP;
      default:                dst_e = REG_NONE;
    endcase
    case (icode)
      4'h5, 4'hB: dst_m = rA;
      default:    dst_m = REG_NONE;
    endcase
  end

  // Status machine, register commits and retire counter; valM is assigned after valE so it wins on a shared destination
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        rf[i] <= (i == 4) ? RSP_RESET_VAL : 64'd0;
      end
      state   <= AOK;
      retired <= '0;
    end else if (instr_valid && state == AOK) begin
      if (icode == 4'h0) begin
        state   <= HLT;
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (icode > 4'hB) begin
        state <= INS;
      end else begin
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        for (int i = 0; i < 15; i++) begin
          if (dst_e == 4'(i)) rf[i] <= valE;
          if (dst_m == 4'(i)) rf[i] <= valM;
        end
      end
    end
  end

  assign stat  = state;
  assign reg0  = rf[0];
  assign reg1  = rf[1];
  assign reg2  = rf[2];
  assign reg3  = rf[3];
  assign reg4  = rf[4];
  assign reg5  = rf[5];
  assign reg6  = rf[6];
  assign reg7  = rf[7];
  assign reg8  = rf[8];
  assign reg9  = rf[9];
  assign reg10 = rf[10];
  assign reg11 = rf[11];
  assign reg12 = rf[12];
  assign reg13 = rf[13];
  assign reg14 = rf[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed vectors with hand-computed expectations for
// the write-back stage / register file. The counter is narrowed to 4 bits so
// the wrap of the retired counter can be reached in a few cycles.
module tb_writeback_regfile;

  localparam int CNT_W = 4;

`ifdef RSP_RESET_EN
  localparam logic [63:0] RSP_EXP = 64'h1000;
`else
  localparam logic [63:0] RSP_EXP = 64'h0;
`endif

  logic             clk;
  logic             rst;
  logic             instr_valid;
  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             Cnd;
  logic [63:0]      valE;
  logic [63:0]      valM;
  logic [63:0]      r [15];
  logic [2:0]       stat;
  logic [CNT_W-1:0] retired;

  int checks;
  int errors;

  writeback_regfile #(.CNT_W(CNT_W), .RSP_INIT(64'h1000)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .icode(icode),
    .rA(rA), .rB(rB), .Cnd(Cnd), .valE(valE), .valM(valM),
    .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]), .reg4(r[4]),
    .reg5(r[5]), .reg6(r[6]), .reg7(r[7]), .reg8(r[8]), .reg9(r[9]),
    .reg10(r[10]), .reg11(r[11]), .reg12(r[12]), .reg13(r[13]), .reg14(r[14]),
    .stat(stat), .retired(retired)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction at the falling edge, let it commit, sample 1 ns after the rising edge
  task automatic applyStimulus(input logic v, input logic [3:0] ic, input logic [3:0] a,
                               input logic [3:0] b, input logic c,
                               input logic [63:0] e, input logic [63:0] m);
    @(negedge clk);
    instr_valid = v;
    icode = ic;
    rA = a;
    rB = b;
    Cnd = c;
    valE = e;
    valM = m;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    instr_valid = 1'b0;
    icode = 4'h1;
    rA = 4'hF;
    rB = 4'hF;
    Cnd = 1'b0;
    valE = '0;
    valM = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // irmovq then OPq into reg2
    applyStimulus(1'b1, 4'h3, 4'hF, 4'd2, 1'b0, 64'h55, 64'h0);
    checkOutput("irmovq_reg2", r[2], 64'h55);
    checkOutput("irmovq_retired", 64'(retired), 64'd1);
    applyStimulus(1'b1, 4'h6, 4'd1, 4'd2, 1'b0, 64'hAA, 64'h0);
    checkOutput("opq_reg2", r[2], 64'hAA);
    checkOutput("opq_retired", 64'(retired), 64'd2);

    // No write-through: value pending before the edge is not visible yet
    @(negedge clk);
    instr_valid = 1'b1; icode = 4'h3; rB = 4'd14; valE = 64'hE;
    #1;
    checkOutput("no_write_through", r[14], 64'h0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    checkOutput("irmovq_reg14", r[14], 64'hE);

    // Asynchronous reset mid-cycle with a pending commit
    @(negedge clk);
    instr_valid = 1'b1; icode = 4'h3; rB = 4'd2; valE = 64'h99;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_reg2", r[2], 64'h0);
    checkOutput("async_rst_reg14", r[14], 64'h0);
    checkOutput("async_rst_reg4", r[4], RSP_EXP);
    checkOutput("async_rst_stat", 64'(stat), 64'd1);
    checkOutput("async_rst_retired", 64'(retired), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_drops_commit", r[2], 64'h0);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // cmov not taken, then taken
    applyStimulus(1'b1, 4'h2, 4'd1, 4'd3, 1'b0, 64'h7, 64'h0);
    checkOutput("cmov_nt_reg3", r[3], 64'h0);
    checkOutput("cmov_nt_retired", 64'(retired), 64'd1);
    applyStimulus(1'b1, 4'h2, 4'd1, 4'd3, 1'b1, 64'h7, 64'h0);
    checkOutput("cmov_t_reg3", r[3], 64'h7);

    // popq %rsp: valM wins over valE
    applyStimulus(1'b1, 4'hB, 4'd4, 4'hF, 1'b0, 64'h1008, 64'h2000);
    checkOutput("popq_rsp_reg4", r[4], 64'h2000);
    checkOutput("popq_rsp_retired", 64'(retired), 64'd3);

    // popq %rbx: both writes land on one edge
    applyStimulus(1'b1, 4'hB, 4'd3, 4'hF, 1'b0, 64'h1010, 64'h77);
    checkOutput("popq_rbx_reg3", r[3], 64'h77);
    checkOutput("popq_rbx_reg4", r[4], 64'h1010);

    // instr_valid low: nothing changes
    applyStimulus(1'b0, 4'h3, 4'hF, 4'd1, 1'b0, 64'h9, 64'h0);
    checkOutput("invalid_reg1", r[1], 64'h0);
    checkOutput("invalid_retired", 64'(retired), 64'd4);

    // mrmovq writes valM to rA only
    applyStimulus(1'b1, 4'h5, 4'd6, 4'd7, 1'b0, 64'h123, 64'hBEEF);
    checkOutput("mrmovq_reg6", r[6], 64'hBEEF);
    checkOutput("mrmovq_reg7", r[7], 64'h0);

    // rmmovq and irmovq to F: retire without writing
    applyStimulus(1'b1, 4'h4, 4'd5, 4'd5, 1'b0, 64'h123, 64'h456);
    checkOutput("rmmovq_reg5", r[5], 64'h0);
    applyStimulus(1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h321, 64'h0);
    checkOutput("nowrite_retired", 64'(retired), 64'd7);

    // halt, then ignored instruction
    applyStimulus(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    checkOutput("halt_stat", 64'(stat), 64'd2);
    checkOutput("halt_retired", 64'(retired), 64'd8);
    applyStimulus(1'b1, 4'h3, 4'hF, 4'd1, 1'b0, 64'h9, 64'h0);
    checkOutput("post_halt_reg1", r[1], 64'h0);
    checkOutput("post_halt_retired", 64'(retired), 64'd8);
    checkOutput("post_halt_stat", 64'(stat), 64'd2);

    // invalid opcode after reset
    applyReset();
    applyStimulus(1'b1, 4'hC, 4'd1, 4'd1, 1'b1, 64'h9, 64'h9);
    checkOutput("ins_stat", 64'(stat), 64'd4);
    checkOutput("ins_retired", 64'(retired), 64'd0);
    checkOutput("ins_reg1", r[1], 64'h0);
    applyStimulus(1'b1, 4'h3, 4'hF, 4'd1, 1'b0, 64'h9, 64'h0);
    checkOutput("post_ins_reg1", r[1], 64'h0);

    // retired counter wraps at 2^CNT_W
    applyReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    end
    checkOutput("wrap_retired", 64'(retired), 64'd1);
    checkOutput("wrap_stat", 64'(stat), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
